pool_out_writer: RTL and testbench
==================================

Name: pool_out_writer

Overview:
- Downstream stage of the pooling engine.
- Captures the packed pooled output words (NUM_PE lanes of OP_WIDTH), buffers them in a FIFO, and writes them to memory as bursts through a simple address/data write channel.
- Each layer is configured with a base address, a word count and a burst length; the block reports busy, done and a sticky overflow.

Parameters:
- OP_WIDTH, 16, lane width in bits.
- NUM_PE, 4, lanes per word.
- DATA_WIDTH, OP_WIDTH*NUM_PE, word width.
- ADDR_WIDTH, 32, byte address width.
- FIFO_ADDR_WIDTH, 5, FIFO depth is 2^FIFO_ADDR_WIDTH words.
- BURST_WIDTH, 4, burst length field width; maximum burst is 2^BURST_WIDTH beats.
- COUNT_WIDTH, 16, words-per-layer counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle start pulse; ignored while busy.
- cfg_base_addr  in  ADDR_WIDTH  byte address of the first word; sampled on an accepted start.
- cfg_num_words  in  COUNT_WIDTH  total words for the layer; sampled on start.
- cfg_burst_len  in  BURST_WIDTH  beats per burst minus 1; sampled on start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; set when a word is dropped, cleared on an accepted start.
- pool_data  in  DATA_WIDTH  pooled word.
- pool_valid  in  1  pooled word valid.
- pool_ready  out  1  equals !fifo_full; advisory only, because the pooling engine does not stall.
- wr_addr_req  out  1  burst address request.
- wr_addr  out  ADDR_WIDTH  burst start byte address.
- wr_burst_len  out  BURST_WIDTH  beats minus 1 for this burst.
- wr_addr_ready  in  1  address accepted.
- wr_data  out  DATA_WIDTH  write beat data, taken from the FIFO head.
- wr_data_valid  out  1  beat valid.
- wr_data_last  out  1  final beat of the burst.
- wr_data_ready  in  1  beat accepted.

Behaviour:

Reset values:
- All outputs are 0; busy=0.
- FIFO empty; FSM in IDLE.
- Internal remaining, address and beat counters are 0.

FIFO:
- Show-ahead: wr_data equals the head word combinationally.
- Push: pool_valid && !full.
- Pop: wr_data_valid && wr_data_ready.
- Push and pop in the same cycle when full: the pop frees a slot, but the push is still refused because full is evaluated pre-pop. The word is dropped and overflow is set.
- Words are accepted in every state, including IDLE. Start does not flush the FIFO.

FSM states:
- IDLE
  - On cfg_start: latch the config, set remaining=cfg_num_words, addr=cfg_base_addr, clear overflow, set busy=1.
  - If cfg_num_words==0 go to FIN, otherwise go to WAIT.
- WAIT
  - Compute beats = min(cfg_burst_len+1, remaining).
  - When fifo_count >= beats, go to ADDR the next cycle.
- ADDR
  - Drive wr_addr_req=1, wr_addr=addr, wr_burst_len=beats-1; hold them stable until wr_addr_ready.
  - On the handshake, go to DATA and set beat_cnt=0.
- DATA
  - wr_data_valid=1 for every cycle in DATA. The FIFO is guaranteed non-empty because WAIT waited for enough words.
  - wr_data_last=1 when beat_cnt==beats-1.
  - Each accepted beat increments beat_cnt.
  - On the accepted last beat:
    - remaining -= beats;
    - addr += beats*(DATA_WIDTH/8), truncated to ADDR_WIDTH (wrap-around permitted);
    - go to FIN if remaining==beats, else WAIT.
- FIN
  - done=1 for exactly one cycle, busy falls in the same cycle, then return to IDLE.

Latency:
- Start with a pre-filled FIFO and wr_addr_ready tied high: wr_addr_req rises 2 cycles after start (IDLE→WAIT→ADDR). The first beat follows 1 cycle after the address handshake.

Other rules:
- cfg_start while busy is ignored, with no side effects.
- Asynchronous reset mid-burst aborts immediately. The FIFO is emptied and all outputs return to reset values. No partial-burst completion is attempted.
- Words pushed after remaining reaches 0 stay in the FIFO for the next layer.

Optional Feature:
- Macro: POOL_OUT_RELU_EN.
- Defined: each OP_WIDTH lane of pool_data is treated as signed. Negative lanes are replaced with 0 before the FIFO push. The operation is combinational and adds no latency.
- Undefined: pool_data is stored unmodified.

Test Plan:
- Basic bursts:
  - Stimulus: base=0x1000, num_words=8, burst_len=3 (4 beats); push 8 words 0..7, ready tied high.
  - Response: two bursts at 0x1000 and 0x1020, each with wr_burst_len=3 and last on beats 3 and 7. Data order is 0..7; one done pulse; busy low afterwards.
- Partial tail burst:
  - Stimulus: num_words=5, burst_len=3.
  - Response: bursts of 4 and 1 beats; the second has wr_burst_len=0 with last on its only beat; second address = base+32.
- Overflow:
  - Stimulus: wr_addr_ready held low; push 40 words into the 32-deep FIFO.
  - Response: pool_ready falls after 32 words; overflow=1 and stays set; exactly 32 words are later written; the next cfg_start clears overflow.
- Zero-count layer and ignored start:
  - Stimulus: cfg_num_words=0.
  - Response: done 2 cycles after start with no wr_addr_req. A second cfg_start pulsed while busy on a normal layer causes no change in the burst sequence.
- Reset mid-burst:
  - Stimulus: drive reset low during the 2nd beat of a 4-beat burst.
  - Response: wr_data_valid, busy and done drop to 0 asynchronously; FIFO empty. After release, a new 4-word layer completes normally.
- ReLU feature:
  - Stimulus: with POOL_OUT_RELU_EN defined, push lanes {0x8001, 0x0005, 0xFFFF, 0x7FFF}.
  - Response: written word {0x0000, 0x0005, 0x0000, 0x7FFF}. With the macro undefined, the word is written unchanged.

Source files
------------

// File: rtl/pool_out_writer.sv
// rtl/pool_out_writer.sv - pooled-word FIFO and burst memory writer
//
// Buffers packed pooled words (NUM_PE lanes of OP_WIDTH) in a show-ahead FIFO
// and writes each layer to memory as address/data bursts.
// Optional feature macro: POOL_OUT_RELU_EN (clamp negative signed lanes to 0 before push).
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cfg_start                  start pulse, ignored while busy
//   cfg_base_addr              first word byte address
//   cfg_num_words              words in the layer
//   cfg_burst_len              beats per burst minus 1
//   busy, done, overflow       status: running, completion pulse, sticky drop flag
//   pool_data, pool_valid      pooled word input (never stalls)
//   pool_ready                 advisory, !fifo_full
//   wr_addr_req/wr_addr/wr_burst_len/wr_addr_ready      burst address channel
//   wr_data/wr_data_valid/wr_data_last/wr_data_ready    burst data channel
module pool_out_writer #(
    parameter int OP_WIDTH        = 16,
    parameter int NUM_PE          = 4,
    parameter int DATA_WIDTH      = OP_WIDTH * NUM_PE,
    parameter int ADDR_WIDTH      = 32,
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int BURST_WIDTH     = 4,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_num_words,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    input  logic [DATA_WIDTH-1:0]  pool_data,
    input  logic                   pool_valid,
    output logic                   pool_ready,
    output logic                   wr_addr_req,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [BURST_WIDTH-1:0] wr_burst_len,
    input  logic                   wr_addr_ready,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_data_valid,
    output logic                   wr_data_last,
    input  logic                   wr_data_ready
);

    localparam int DEPTH      = 1 << FIFO_ADDR_WIDTH;
    localparam int BEAT_WIDTH = BURST_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_FIN} state_t;

    logic [DATA_WIDTH-1:0]      push_data;
    logic [DATA_WIDTH-1:0]      mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wptr;
    logic [FIFO_ADDR_WIDTH-1:0] rptr;
    logic [FIFO_ADDR_WIDTH:0]   count;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;
    logic                       drop;

    state_t                     state;
    logic [BURST_WIDTH-1:0]     burst_len_q;
    logic [COUNT_WIDTH-1:0]     remaining;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [BEAT_WIDTH-1:0]      beats_q;
    logic [BEAT_WIDTH-1:0]      beat_cnt;
    logic [BEAT_WIDTH-1:0]      burst_max;
    logic [BEAT_WIDTH-1:0]      beats_next;

`ifdef POOL_OUT_RELU_EN
    always_comb begin
        push_data = pool_data;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pool_data[i*OP_WIDTH + OP_WIDTH - 1])
                push_data[i*OP_WIDTH +: OP_WIDTH] = '0;
        end
    end
`else
    assign push_data = pool_data;
`endif

    // Full is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign fifo_full  = (count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
    assign push       = pool_valid && !fifo_full;
    assign drop       = pool_valid && fifo_full;
    assign pop        = wr_data_valid && wr_data_ready;
    assign pool_ready = !fifo_full;
    assign wr_data    = mem[rptr];
    assign wr_addr    = addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    // Beats for the next burst: the configured length, clipped to the words left.
    assign burst_max  = {1'b0, burst_len_q} + BEAT_WIDTH'(1);
    assign beats_next = (remaining < COUNT_WIDTH'(burst_max)) ? BEAT_WIDTH'(remaining) : burst_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            burst_len_q   <= '0;
            remaining     <= '0;
            addr          <= '0;
            beats_q       <= '0;
            beat_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            wr_addr_req   <= 1'b0;
            wr_burst_len  <= '0;
            wr_data_valid <= 1'b0;
            wr_data_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        burst_len_q <= cfg_burst_len;
                        remaining   <= cfg_num_words;
                        addr        <= cfg_base_addr;
                        busy        <= 1'b1;
                        overflow    <= drop;
                        state       <= (cfg_num_words == '0) ? S_FIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (32'(count) >= 32'(beats_next)) begin
                        beats_q      <= beats_next;
                        wr_burst_len <= BURST_WIDTH'(beats_next - BEAT_WIDTH'(1));
                        wr_addr_req  <= 1'b1;
                        state        <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (wr_addr_ready) begin
                        wr_addr_req   <= 1'b0;
                        beat_cnt      <= '0;
                        wr_data_valid <= 1'b1;
                        wr_data_last  <= (beats_q == BEAT_WIDTH'(1));
                        state         <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (pop) begin
                        if (beat_cnt == beats_q - BEAT_WIDTH'(1)) begin
                            wr_data_valid <= 1'b0;
                            wr_data_last  <= 1'b0;
                            remaining     <= remaining - COUNT_WIDTH'(beats_q);
                            addr          <= addr + ADDR_WIDTH'(beats_q) * WORD_BYTES;
                            state         <= (remaining == COUNT_WIDTH'(beats_q)) ? S_FIN : S_WAIT;
                        end else begin
                            beat_cnt     <= beat_cnt + BEAT_WIDTH'(1);
                            wr_data_last <= (beat_cnt + BEAT_WIDTH'(2) == beats_q);
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_out_writer.sv
// tb/tb_pool_out_writer.sv - directed self-checking bench for pool_out_writer
module tb_pool_out_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_num_words;
    logic [3:0]  cfg_burst_len;
    logic        busy, done, overflow;
    logic [63:0] pool_data;
    logic        pool_valid, pool_ready;
    logic        wr_addr_req;
    logic [31:0] wr_addr;
    logic [3:0]  wr_burst_len;
    logic        wr_addr_ready;
    logic [63:0] wr_data;
    logic        wr_data_valid, wr_data_last, wr_data_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_q [$];
    logic [3:0]  bl_q [$];
    logic [63:0] data_q [$];
    bit          last_q [$];
    int          done_cnt = 0;

    pool_out_writer dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_num_words(cfg_num_words), .cfg_burst_len(cfg_burst_len),
        .busy(busy), .done(done), .overflow(overflow),
        .pool_data(pool_data), .pool_valid(pool_valid), .pool_ready(pool_ready),
        .wr_addr_req(wr_addr_req), .wr_addr(wr_addr), .wr_burst_len(wr_burst_len),
        .wr_addr_ready(wr_addr_ready),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_last(wr_data_last),
        .wr_data_ready(wr_data_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_addr_req && wr_addr_ready) begin
            addr_q.push_back(wr_addr);
            bl_q.push_back(wr_burst_len);
        end
        if (wr_data_valid && wr_data_ready) begin
            data_q.push_back(wr_data);
            last_q.push_back(wr_data_last);
        end
        if (done) done_cnt++;
    end

    task automatic push_one(input logic [63:0] d);
        pool_data  = d;
        pool_valid = 1'b1;
        @(posedge clk); #1;
        pool_valid = 1'b0;
    endtask

    task automatic push_words(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) push_one(first + 64'(i));
    endtask

    task automatic start_layer(input logic [31:0] base, input logic [15:0] n, input logic [3:0] bl);
        cfg_base_addr = base;
        cfg_num_words = n;
        cfg_burst_len = bl;
        cfg_start     = 1'b1;
        @(posedge clk); #1;
        cfg_start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (wr_addr_req !== 1'b0) begin errors++; $display("FAIL reset_addr_req got %b want 0", wr_addr_req); end
        checks++; if (wr_data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", wr_data_valid); end
        checks++; if (wr_data_last !== 1'b0) begin errors++; $display("FAIL reset_data_last got %b want 0", wr_data_last); end
        checks++; if (wr_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr); end
        checks++; if (wr_burst_len !== 4'h0) begin errors++; $display("FAIL reset_burst_len got %h want 0", wr_burst_len); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int a0, d0, dc0;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size(); dc0 = done_cnt;
        push_words(64'd0, 8);
        start_layer(32'h1000, 16'd8, 4'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if (wr_addr_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got %b want 0", wr_addr_req); end
        @(posedge clk); #1;
        checks++; if (wr_addr_req !== 1'b1) begin errors++; $display("FAIL basic_req_latency got %b want 1", wr_addr_req); end
        checks++; if (wr_addr !== 32'h1000) begin errors++; $display("FAIL basic_first_addr got %h want 1000", wr_addr); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
        repeat (2) @(posedge clk); #1;
        checks++; if (addr_q.size() - a0 !== 2) begin errors++; $display("FAIL basic_bursts got %0d want 2", addr_q.size() - a0); end
        checks++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - dc0); end
        if (addr_q.size() - a0 == 2) begin
            checks++; if (addr_q[a0+1] !== 32'h1020) begin errors++; $display("FAIL basic_addr2 got %h want 1020", addr_q[a0+1]); end
            checks++; if (bl_q[a0] !== 4'd3 || bl_q[a0+1] !== 4'd3) begin errors++; $display("FAIL basic_burst_len got %0d,%0d want 3,3", bl_q[a0], bl_q[a0+1]); end
        end
        checks++;
        if (data_q.size() - d0 !== 8) begin
            errors++; $display("FAIL basic_beats got %0d want 8", data_q.size() - d0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (data_q[d0+i] !== 64'(i) || last_q[d0+i] !== (i == 3 || i == 7)) begin
                    errors++; $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, data_q[d0+i], last_q[d0+i], 64'(i), (i == 3 || i == 7));
                end
            end
        end
    endtask

    task automatic test_partial;
        int a0, d0;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size();
        push_words(64'd10, 2);
        start_layer(32'h2000, 16'd5, 4'd3);
        push_words(64'd12, 3);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_done_timeout got 0 want 1"); end
        checks++;
        if (addr_q.size() - a0 !== 2) begin
            errors++; $display("FAIL partial_bursts got %0d want 2", addr_q.size() - a0);
        end else begin
            checks++; if (addr_q[a0] !== 32'h2000 || addr_q[a0+1] !== 32'h2020) begin errors++; $display("FAIL partial_addr got %h,%h want 2000,2020", addr_q[a0], addr_q[a0+1]); end
            checks++; if (bl_q[a0] !== 4'd3 || bl_q[a0+1] !== 4'd0) begin errors++; $display("FAIL partial_burst_len got %0d,%0d want 3,0", bl_q[a0], bl_q[a0+1]); end
        end
        checks++;
        if (data_q.size() - d0 !== 5) begin
            errors++; $display("FAIL partial_beats got %0d want 5", data_q.size() - d0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (data_q[d0+i] !== 64'(10 + i) || last_q[d0+i] !== (i >= 3)) begin
                    errors++; $display("FAIL partial_beat%0d got %h/%b want %h/%b", i, data_q[d0+i], last_q[d0+i], 64'(10 + i), (i >= 3));
                end
            end
        end
    endtask

    task automatic test_overflow;
        int a0, d0;
        bit ok;
        a0 = addr_q.size(); d0 = data_q.size();
        wr_addr_ready = 1'b0;
        start_layer(32'h3000, 16'd32, 4'd15);
        for (int i = 0; i < 40; i++) begin
            if (i == 32) begin
                checks++; if (pool_ready !== 1'b0) begin errors++; $display("FAIL ovf_pool_ready got %b want 0", pool_ready); end
            end
            push_one(64'(100 + i));
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        wr_addr_ready = 1'b1;
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout got 0 want 1"); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        checks++;
        if (addr_q.size() - a0 !== 2) begin
            errors++; $display("FAIL ovf_bursts got %0d want 2", addr_q.size() - a0);
        end else begin
            checks++; if (addr_q[a0+1] !== 32'h3080 || bl_q[a0+1] !== 4'd15) begin errors++; $display("FAIL ovf_addr2 got %h/%0d want 3080/15", addr_q[a0+1], bl_q[a0+1]); end
        end
        checks++;
        if (data_q.size() - d0 !== 32) begin
            errors++; $display("FAIL ovf_beats got %0d want 32", data_q.size() - d0);
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (data_q[d0+i] !== 64'(100 + i)) begin
                    errors++; $display("FAIL ovf_beat%0d got %h want %h", i, data_q[d0+i], 64'(100 + i));
                end
            end
        end
    endtask

    task automatic test_zero_and_ignored_start;
        int a0, d0, dc0;
        bit ok;
        a0 = addr_q.size();
        start_layer(32'h0, 16'd0, 4'd0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf_clear got %b want 0", overflow); end
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_cycle1 got done %b busy %b want 0 1", done, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_cycle2 got done %b busy %b want 1 0", done, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got %b want 0", done); end
        checks++; if (addr_q.size() !== a0) begin errors++; $display("FAIL zero_no_req got %0d want %0d", addr_q.size(), a0); end

        a0 = addr_q.size(); d0 = data_q.size(); dc0 = done_cnt;
        push_words(64'd50, 4);
        start_layer(32'h4000, 16'd4, 4'd3);
        start_layer(32'h9000, 16'd1, 4'd0);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout got 0 want 1"); end
        repeat (6) @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", busy); end
        checks++; if (done_cnt - dc0 !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt - dc0); end
        checks++;
        if (addr_q.size() - a0 !== 1) begin
            errors++; $display("FAIL ign_bursts got %0d want 1", addr_q.size() - a0);
        end else if (addr_q[a0] !== 32'h4000 || bl_q[a0] !== 4'd3) begin
            errors++; $display("FAIL ign_addr got %h/%0d want 4000/3", addr_q[a0], bl_q[a0]);
        end
        checks++;
        if (data_q.size() - d0 !== 4 || data_q[data_q.size()-1] !== 64'd53) begin
            errors++; $display("FAIL ign_beats got %0d beats want 4 ending 53", data_q.size() - d0);
        end
    endtask

    task automatic test_reset_mid_burst;
        int d0;
        bit ok, seen;
        push_words(64'd200, 4);
        start_layer(32'h5000, 16'd4, 4'd3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wr_data_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_first_beat_timeout got 0 want 1"); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (wr_data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got %b want 0", wr_data_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b %b want 0 0", busy, done); end
        checks++; if (wr_addr_req !== 1'b0) begin errors++; $display("FAIL rst_addr_req got %b want 0", wr_addr_req); end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        d0 = data_q.size();
        push_words(64'd300, 4);
        start_layer(32'h6000, 16'd4, 4'd3);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_relayer_timeout got 0 want 1"); end
        checks++;
        if (data_q.size() - d0 !== 4) begin
            errors++; $display("FAIL rst_relayer_beats got %0d want 4", data_q.size() - d0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (data_q[d0+i] !== 64'(300 + i)) begin
                    errors++; $display("FAIL rst_relayer_beat%0d got %h want %h", i, data_q[d0+i], 64'(300 + i));
                end
            end
        end
    endtask

    task automatic test_relu;
        int d0;
        bit ok;
        logic [63:0] expected;
`ifdef POOL_OUT_RELU_EN
        expected = {16'h0000, 16'h0005, 16'h0000, 16'h7FFF};
`else
        expected = {16'h8001, 16'h0005, 16'hFFFF, 16'h7FFF};
`endif
        d0 = data_q.size();
        push_one({16'h8001, 16'h0005, 16'hFFFF, 16'h7FFF});
        start_layer(32'h7000, 16'd1, 4'd0);
        wait_done(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL relu_done_timeout got 0 want 1"); end
        checks++;
        if (data_q.size() - d0 !== 1) begin
            errors++; $display("FAIL relu_beats got %0d want 1", data_q.size() - d0);
        end else if (data_q[d0] !== expected) begin
            errors++; $display("FAIL relu_word got %h want %h", data_q[d0], expected);
        end
    endtask

    initial begin
        reset         = 1'b0;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_num_words = '0;
        cfg_burst_len = '0;
        pool_data     = '0;
        pool_valid    = 1'b0;
        wr_addr_ready = 1'b1;
        wr_data_ready = 1'b1;
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_zero_and_ignored_start();
        test_reset_mid_burst();
        test_relu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
